// File: rtl/cla_add_scheduler.sv
// Two-requester sequencer for a shared 32-bit carry-lookahead adder (no carry-in).
// Subtract runs as a negate pass (~B + 1) followed by an add pass.
module cla_add_scheduler #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_ovf,
  input  logic        resp_ready,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_en,
  input  logic [31:0] add_s,
  input  logic        add_cout
);

  typedef enum logic [1:0] {StIdle, StNeg, StAdd, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic        op_q, op_d, id_q, id_d, bsign_q, bsign_d, ovf_q, ovf_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_any, grant_id, idle;
  logic [31:0] sel_b;

  // Arbiter: the only combinational path from requester inputs to outputs.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ROUND_ROBIN ? ~last_grant_q : 1'b0;
    end else begin
      grant_id = req1_valid;
    end
    // Gated with reset so every output reads 0 while reset is held.
    idle       = (state_q == StIdle) && reset;
    req0_ready = idle && req0_valid && !grant_id;
    req1_ready = idle && req1_valid && grant_id;
    sel_b      = grant_id ? req1_b : req0_b;
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    op_d         = op_q;
    id_d         = id_q;
    bsign_d      = bsign_q;
    ovf_d        = ovf_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          a_d          = grant_id ? req1_a : req0_a;
          b_d          = sel_b;
          op_d         = grant_id ? req1_op : req0_op;
          id_d         = grant_id;
          bsign_d      = sel_b[31];
          last_grant_d = grant_id;
          state_d      = op_d ? StNeg : StAdd;
        end
      end
      StNeg: begin
        b_d     = add_s;
        state_d = StAdd;
      end
      StAdd: begin
        res_d   = add_s;
        // Subtract overflow uses the original B sign, so 0 - 0x80000000 flags.
        ovf_d   = op_q ? ((a_q[31] ^ bsign_q) & (add_s[31] ^ a_q[31])) : add_cout;
        state_d = StResp;
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      op_q         <= 1'b0;
      id_q         <= 1'b0;
      bsign_q      <= 1'b0;
      ovf_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      op_q         <= op_d;
      id_q         <= id_d;
      bsign_q      <= bsign_d;
      ovf_q        <= ovf_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    add_en = 1'b0;
    add_a  = '0;
    add_b  = '0;
    if (state_q == StNeg) begin
      add_en = 1'b1;
      add_a  = ~b_q;
      add_b  = 32'h1;
    end else if (state_q == StAdd) begin
      add_en = 1'b1;
      add_a  = a_q;
      add_b  = b_q;
    end
  end

  assign resp_valid  = (state_q == StResp);
  assign resp_id     = id_q;
  assign resp_result = res_q;
  assign resp_ovf    = ovf_q;

endmodule
